// File: rtl/vga_timing_gen.sv
// VGA timing generator with programmable geometry, sync polarity, pixel-clock
// divider, pause input, line/frame strobes, frame counter and a flag delay line.
//
// Ports:
//   i_clk          pixel/system clock
//   i_reset        synchronous active-high reset
//   i_enable       1 = run, 0 = freeze divider, position and frame counter
//   o_pix_en       high in cycles where the position advances on the next edge
//   o_hpos/o_vpos  current column/line (never delayed)
//   o_display_on   visible-area flag            (delayed by SYNC_DELAY)
//   o_hsync        hsync at H_SYNC_POL          (delayed by SYNC_DELAY)
//   o_vsync        vsync at V_SYNC_POL          (delayed by SYNC_DELAY)
//   o_line_start   one-clk pulse at hpos -> 0   (delayed by SYNC_DELAY)
//   o_frame_start  one-clk pulse at (0,0)       (delayed by SYNC_DELAY)
//   o_frame_cnt    completed frames, wraps modulo 2^FRAME_W
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned FRAME_W    = 16,
  parameter int unsigned SYNC_DELAY = 0,
  parameter int unsigned COORD_W    = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  output logic               o_pix_en,
  output logic [COORD_W-1:0] o_hpos,
  output logic [COORD_W-1:0] o_vpos,
  output logic               o_display_on,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic [FRAME_W-1:0] o_frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_MAX     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_MAX     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS     = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS     = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] H_SYNC_LO = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] H_SYNC_HI = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] V_SYNC_LO = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] V_SYNC_HI = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);

  // Flag vector layout: {display_on, hsync, vsync, line_start, frame_start}
  localparam logic [4:0] FLAGS_RST = {1'b0, ~H_SYNC_POL, ~V_SYNC_POL, 2'b00};

  logic [DIV_W-1:0]   r_div_cnt;
  logic [COORD_W-1:0] r_hpos;
  logic [COORD_W-1:0] r_vpos;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [4:0]         r_flags;

  logic               w_div_wrap;
  logic               w_pix_en;
  logic [COORD_W-1:0] w_next_h;
  logic [COORD_W-1:0] w_next_v;
  logic [4:0]         w_flags_next;
  logic [4:0]         w_flags_out;

  assign w_div_wrap = (r_div_cnt == DIV_MAX);
  assign w_pix_en   = ~i_reset & i_enable & w_div_wrap;

  always_comb begin
    w_next_h = r_hpos + 1'b1;
    w_next_v = r_vpos;
    if (r_hpos == H_MAX) begin
      w_next_h = '0;
      w_next_v = (r_vpos == V_MAX) ? '0 : r_vpos + 1'b1;
    end
  end

  // Flags are derived from the position being entered so they line up with it.
  always_comb begin
    w_flags_next    = FLAGS_RST;
    w_flags_next[4] = (w_next_h < H_VIS) && (w_next_v < V_VIS);
    w_flags_next[3] = ((w_next_h >= H_SYNC_LO) && (w_next_h < H_SYNC_HI)) ?
                      H_SYNC_POL : ~H_SYNC_POL;
    w_flags_next[2] = ((w_next_v >= V_SYNC_LO) && (w_next_v < V_SYNC_HI)) ?
                      V_SYNC_POL : ~V_SYNC_POL;
    w_flags_next[1] = (w_next_h == '0);
    w_flags_next[0] = (w_next_h == '0) && (w_next_v == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_cnt   <= '0;
      r_hpos      <= '0;
      r_vpos      <= '0;
      r_frame_cnt <= '0;
      r_flags     <= FLAGS_RST;
    end else begin
      if (i_enable) begin
        r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
      end
      if (w_pix_en) begin
        r_hpos  <= w_next_h;
        r_vpos  <= w_next_v;
        r_flags <= w_flags_next;
        if (w_flags_next[0]) begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end else begin
        // Strobes last exactly one clk even when pixels span several clks.
        r_flags[1:0] <= 2'b00;
      end
    end
  end

  if (SYNC_DELAY == 0) begin : g_no_dly
    assign w_flags_out = r_flags;
  end else begin : g_dly
    logic [4:0] r_dly [SYNC_DELAY];

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        for (int i = 0; i < int'(SYNC_DELAY); i++) begin
          r_dly[i] <= FLAGS_RST;
        end
      end else begin
        r_dly[0] <= r_flags;
        for (int i = 1; i < int'(SYNC_DELAY); i++) begin
          r_dly[i] <= r_dly[i-1];
        end
      end
    end

    assign w_flags_out = r_dly[SYNC_DELAY-1];
  end

  assign o_pix_en      = w_pix_en;
  assign o_hpos        = r_hpos;
  assign o_vpos        = r_vpos;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_display_on  = w_flags_out[4];
  assign o_hsync       = w_flags_out[3];
  assign o_vsync       = w_flags_out[2];
  assign o_line_start  = w_flags_out[1];
  assign o_frame_start = w_flags_out[0];

endmodule
